// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle floating-point unit among NREQ requesters.
// Define FP_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts a job after TIMEOUT cycles.
module fp_unit_arbiter #(
    parameter int NREQ     = 4,
    parameter int fp_width = 32,
    parameter int op_width = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*op_width-1:0]   req_op,
    input  logic [NREQ*fp_width-1:0]   req_dataa,
    input  logic [NREQ*fp_width-1:0]   req_datab,
    output logic [NREQ-1:0]            grant,
    output logic [NREQ-1:0]            req_done,
    output logic [fp_width-1:0]        req_result,
    output logic                       req_err,
    output logic                       busy,
    output logic                       fp_clk_en,
    output logic                       fp_start,
    output logic [op_width-1:0]        fp_n,
    output logic [fp_width-1:0]        fp_dataa,
    output logic [fp_width-1:0]        fp_datab,
    output logic                       fp_reset_req,
    input  logic                       fp_done,
    input  logic [fp_width-1:0]        fp_result
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [IDXW-1:0]       last_grant_q, last_grant_d;
    logic [IDXW-1:0]       owner_q, owner_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic [op_width-1:0]   fp_n_q, fp_n_d;
    logic [fp_width-1:0]   dataa_q, dataa_d;
    logic [fp_width-1:0]   datab_q, datab_d;
    logic [fp_width-1:0]   result_q, result_d;

    logic                  found;
    logic [IDXW-1:0]       win_idx;
    logic [NREQ-1:0]       win_oh;
    logic [op_width-1:0]   win_op;
    logic [fp_width-1:0]   win_a;
    logic [fp_width-1:0]   win_b;

    // Two passes over the requesters: first those above last_grant, then the wrap-around.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        win_op  = '0;
        win_a   = '0;
        win_b   = '0;
        for (int k = 0; k < 2 * NREQ; k++) begin
            if (!found && req[k % NREQ] &&
                ((k < NREQ) ? ((k % NREQ) > int'(last_grant_q))
                            : ((k % NREQ) <= int'(last_grant_q)))) begin
                found              = 1'b1;
                win_idx            = IDXW'(k % NREQ);
                win_oh[k % NREQ]   = 1'b1;
                win_op             = req_op[(k % NREQ) * op_width +: op_width];
                win_a              = req_dataa[(k % NREQ) * fp_width +: fp_width];
                win_b              = req_datab[(k % NREQ) * fp_width +: fp_width];
            end
        end
    end

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            tmo_hit;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        fp_n_d       = fp_n_q;
        dataa_d      = dataa_q;
        datab_d      = datab_q;
        result_d     = result_q;
        fp_start     = 1'b0;
        fp_clk_en    = 1'b0;
        req_done     = '0;
`ifdef FP_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
        tmo_hit      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = win_idx;
                    grant_d = win_oh;
                    fp_n_d  = win_op;
                    dataa_d = win_a;
                    datab_d = win_b;
                    state_d = ISSUE;
`ifdef FP_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                fp_start  = 1'b1;
                fp_clk_en = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                fp_clk_en = 1'b1;
                if (fp_done) begin
                    result_d = fp_result;
                    state_d  = RESP;
`ifdef FP_ARB_TIMEOUT_EN
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    tmo_hit  = 1'b1;
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d    = cnt_q + CNTW'(1);
`endif
                end
            end
            RESP: begin
                req_done     = grant_q;
                last_grant_d = owner_q;
                grant_d      = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDXW'(NREQ - 1);
            owner_q      <= '0;
            grant_q      <= '0;
            fp_n_q       <= '0;
            dataa_q      <= '0;
            datab_q      <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            fp_n_q       <= fp_n_d;
            dataa_q      <= dataa_d;
            datab_q      <= datab_d;
            result_q     <= result_d;
        end
    end

`ifdef FP_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fp_reset_req = tmo_hit;
    assign req_err      = err_q & (state_q == RESP);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign fp_reset_req   = 1'b0;
    assign req_err        = 1'b0;
`endif

    assign grant      = grant_q;
    assign req_result = result_q;
    assign busy       = (state_q != IDLE);
    assign fp_n       = fp_n_q;
    assign fp_dataa   = dataa_q;
    assign fp_datab   = datab_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: job-level reference model, fp unit model, directed and random stimulus.
module tb_fp_unit_arbiter;
    localparam int NREQ = 4;
    localparam int FW   = 32;
    localparam int OW   = 8;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*OW-1:0]   req_op;
    logic [NREQ*FW-1:0]   req_dataa;
    logic [NREQ*FW-1:0]   req_datab;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      req_done;
    logic [FW-1:0]        req_result;
    logic                 req_err;
    logic                 busy;
    logic                 fp_clk_en;
    logic                 fp_start;
    logic [OW-1:0]        fp_n;
    logic [FW-1:0]        fp_dataa;
    logic [FW-1:0]        fp_datab;
    logic                 fp_reset_req;
    logic                 fp_done;
    logic [FW-1:0]        fp_result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fp_unit_arbiter #(.NREQ(NREQ), .fp_width(FW), .op_width(OW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_dataa(req_dataa),
        .req_datab(req_datab), .grant(grant), .req_done(req_done), .req_result(req_result),
        .req_err(req_err), .busy(busy), .fp_clk_en(fp_clk_en), .fp_start(fp_start),
        .fp_n(fp_n), .fp_dataa(fp_dataa), .fp_datab(fp_datab), .fp_reset_req(fp_reset_req),
        .fp_done(fp_done), .fp_result(fp_result)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_grant"}, grant, 0);
        chk({pfx, "_req_done"}, req_done, 0);
        chk({pfx, "_req_result"}, req_result, 0);
        chk({pfx, "_req_err"}, req_err, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_fp_clk_en"}, fp_clk_en, 0);
        chk({pfx, "_fp_start"}, fp_start, 0);
        chk({pfx, "_fp_n"}, fp_n, 0);
        chk({pfx, "_fp_dataa"}, fp_dataa, 0);
        chk({pfx, "_fp_datab"}, fp_datab, 0);
        chk({pfx, "_fp_reset_req"}, fp_reset_req, 0);
    endtask

    // Unit function: op 2 converts an unsigned integer to single precision (truncating).
    function automatic logic [FW-1:0] fp_func(input logic [OW-1:0] op, input logic [FW-1:0] a,
                                               input logic [FW-1:0] b);
        int p;
        logic [FW-1:0] m;
        if (op == 8'd2) begin
            if (a == 0) return '0;
            p = 31;
            while (!a[p]) p--;
            m = (p > 23) ? (a >> (p - 23)) : (a << (23 - p));
            return {1'b0, 8'(127 + p), m[22:0]};
        end
        return (a ^ {b[15:0], b[31:16]}) + {24'd0, op};
    endfunction

    // ---------------- floating-point unit model ----------------
    int            u_cnt = 0;
    int            u_lat_fix = 0;
    bit            u_hang = 1'b0;
    logic [FW-1:0] u_res;

    initial begin
        fp_done   = 1'b0;
        fp_result = '0;
        forever begin
            @(posedge clk);
            #1;
            fp_done   = 1'b0;
            fp_result = $urandom();
            if (rst) begin
                u_cnt = 0;
            end else begin
                if (u_cnt > 0) begin
                    u_cnt--;
                    if (u_cnt == 0 && !u_hang) begin
                        fp_done   = 1'b1;
                        fp_result = u_res;
                    end
                end
                if (fp_start) begin
                    u_cnt = (u_lat_fix > 0) ? u_lat_fix : int'($urandom_range(1, 8));
                    u_res = fp_func(fp_n, fp_dataa, fp_datab);
                end else if (!fp_clk_en && u_cnt == 0 && $urandom_range(0, 9) == 0) begin
                    fp_done = 1'b1;  // stray done while no job is waiting
                end
            end
        end
    end

    // ---------------- reference model, monitor and scoreboard ----------------
    bit              m_job, m_resp, m_err;
    int              m_owner, m_age, m_last;
    logic [OW-1:0]   m_op;
    logic [FW-1:0]   m_a, m_b, m_res, sb;
    logic [FW-1:0]   exp_q[$];
    logic [NREQ-1:0] e_grant, e_done, prev_grant;
    logic            e_rstreq;
    int              gnt_log[$];
    int              start_cyc, start_count, fpdone_cyc, rstreq_cyc;

    initial begin
        m_job = 0; m_resp = 0; m_err = 0; m_owner = 0; m_age = 0; m_last = NREQ - 1;
        m_op = '0; m_a = '0; m_b = '0; m_res = '0; prev_grant = '0;
        start_cyc = 0; start_count = 0; fpdone_cyc = 0; rstreq_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_job = 0; m_resp = 0; m_err = 0; m_last = NREQ - 1;
                m_op = '0; m_a = '0; m_b = '0; m_res = '0;
                exp_q.delete();
                prev_grant = '0;
                chk_zero("reset");
            end else begin
                e_grant = '0;
                e_done  = '0;
                if (m_job) e_grant[m_owner] = 1'b1;
                if (m_job && m_resp) e_done[m_owner] = 1'b1;
`ifdef FP_ARB_TIMEOUT_EN
                e_rstreq = m_job && !m_resp && m_age == TO && !fp_done;
`else
                e_rstreq = 1'b0;
`endif
                chk("grant", grant, e_grant);
                chk("req_done", req_done, e_done);
                chk("busy", busy, m_job);
                chk("fp_start", fp_start, m_job && m_age == 0);
                chk("fp_clk_en", fp_clk_en, m_job && !m_resp);
                chk("req_err", req_err, m_resp && m_err);
                chk("fp_reset_req", fp_reset_req, e_rstreq);
                chk("fp_n", fp_n, m_op);
                chk("fp_dataa", fp_dataa, m_a);
                chk("fp_datab", fp_datab, m_b);
                chk("req_result", req_result, m_res);
                if (e_done != 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: got result 0x%0h, required an issued job", req_result);
                    end else begin
                        sb = exp_q.pop_front();
                        chk("scoreboard_result", req_result, m_err ? '0 : sb);
                    end
                end

                if (grant != 0 && prev_grant == 0) begin
                    for (int i = 0; i < NREQ; i++) if (grant[i]) gnt_log.push_back(i);
                end
                prev_grant = grant;
                if (fp_start) begin
                    start_cyc = cyc;
                    start_count++;
                end
                if (fp_done && fp_clk_en && !fp_start) fpdone_cyc = cyc;
                if (fp_reset_req) rstreq_cyc = cyc;

                if (!m_job) begin
                    if (req != 0) begin
                        for (int off = 1; off <= NREQ; off++) begin
                            if (req[(m_last + off) % NREQ]) begin
                                m_owner = (m_last + off) % NREQ;
                                break;
                            end
                        end
                        m_job = 1; m_age = 0; m_err = 0;
                        m_op = req_op[m_owner*OW +: OW];
                        m_a  = req_dataa[m_owner*FW +: FW];
                        m_b  = req_datab[m_owner*FW +: FW];
                        exp_q.push_back(fp_func(m_op, m_a, m_b));
                    end
                end else if (m_resp) begin
                    m_job  = 0;
                    m_resp = 0;
                    m_last = m_owner;
                end else begin
                    if (m_age >= 1 && fp_done) begin
                        m_resp = 1;
                        m_res  = fp_result;
`ifdef FP_ARB_TIMEOUT_EN
                    end else if (m_age == TO) begin
                        m_resp = 1;
                        m_res  = '0;
                        m_err  = 1;
`endif
                    end
                    m_age++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [OW-1:0] op, input logic [FW-1:0] a,
                           input logic [FW-1:0] b);
        req_op[i*OW +: OW]    = op;
        req_dataa[i*FW +: FW] = a;
        req_datab[i*FW +: FW] = b;
        req[i]                = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: req_done[idx], 1: grant[idx], 2: idle, 3: fp_start
    task automatic wait_ev(input string name, input int mode, input int idx, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            case (mode)
                0: ok = req_done[idx];
                1: ok = grant[idx];
                2: ok = !busy;
                default: ok = fp_start;
            endcase
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: event not seen, required within %0d cycles", name, budget);
        end
    endtask

    task automatic rand_drive(input bit allow_raise);
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && req_done[i]) begin
                req[i] = 1'b0;
            end else if (req[i] && grant[i] && $urandom_range(0, 15) == 0) begin
                req[i] = 1'b0;
            end else if (allow_raise && !req[i] && !grant[i] && $urandom_range(0, 3) == 0) begin
                set_req(i, OW'($urandom_range(0, 3)), $urandom(), $urandom());
            end else if ($urandom_range(0, 7) == 0) begin
                req_op[i*OW +: OW]    = OW'($urandom_range(0, 3));
                req_dataa[i*FW +: FW] = $urandom();
                req_datab[i*FW +: FW] = $urandom();
            end
        end
    endtask

    // ---------------- test sequence ----------------
    logic [FW-1:0] iso_a, iso_b;
    int            c0;

    initial begin
        rst = 1'b1; req = '0; req_op = '0; req_dataa = '0; req_datab = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post_reset_busy", busy, 0);
        chk("post_reset_grant", grant, 0);

        // single job: int-to-float of 5
        u_lat_fix   = 6;
        start_count = 0;
        set_req(0, 8'd2, 32'h0000_0005, 32'h0);
        c0 = cyc;
        wait_ev("single_done", 0, 0, 30);
        chk("single_start_latency", start_cyc, c0 + 1);
        chk("single_start_count", start_count, 1);
        chk("single_done_after_fp_done", cyc, fpdone_cyc + 1);
        chk("single_fp_latency", cyc - start_cyc, 7);
        chk("single_result", req_result, 32'h40A0_0000);
        chk("single_err", req_err, 0);
        chk("single_done_owner", req_done, 4'b0001);
        req[0] = 1'b0;
        wait_ev("single_idle", 2, 0, 5);

        // reset in the middle of WAIT
        u_lat_fix = 20;
        set_req(1, 8'd1, $urandom(), $urandom());
        wait_ev("rst_start", 3, 0, 5);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        req = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_release_busy", busy, 0);
        chk("rst_release_grant", grant, 0);

        // round robin with all four requesting
        u_lat_fix = 0;
        gnt_log.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, OW'($urandom_range(0, 3)), $urandom(), $urandom());
        for (int n = 0; n < 300 && gnt_log.size() < 8; n++) tick();
        req = '0;
        chk("rr_grant_count", gnt_log.size() >= 8, 1);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++)
            chk($sformatf("rr_grant_%0d", k), gnt_log[k], k % 4);
        wait_ev("rr_idle", 2, 0, 40);

        // operand isolation after grant
        iso_a = $urandom();
        iso_b = $urandom();
        set_req(1, 8'd1, iso_a, iso_b);
        wait_ev("iso_grant", 1, 1, 5);
        req_dataa[1*FW +: FW] = ~iso_a;
        req_datab[1*FW +: FW] = ~iso_b;
        req_op[1*OW +: OW]    = 8'd3;
        wait_ev("iso_done", 0, 1, 30);
        chk("iso_fp_dataa", fp_dataa, iso_a);
        chk("iso_result", req_result, fp_func(8'd1, iso_a, iso_b));
        req[1] = 1'b0;
        wait_ev("iso_idle", 2, 0, 5);

        // requester 2 drops its request after grant
        set_req(2, 8'd0, $urandom(), $urandom());
        wait_ev("drop_grant", 1, 2, 5);
        req[2] = 1'b0;
        set_req(0, 8'd1, $urandom(), $urandom());
        set_req(3, 8'd1, $urandom(), $urandom());
        wait_ev("drop_done", 0, 2, 30);
        repeat (2) tick();
        chk("drop_next_grant", grant, 4'b1000);
        req = '0;
        wait_ev("drop_idle", 2, 0, 40);

        // random traffic, then drain
        for (int n = 0; n < 3000; n++) begin
            tick();
            rand_drive(1'b1);
        end
        for (int n = 0; n < 400 && req != 0; n++) begin
            tick();
            rand_drive(1'b0);
        end
        req = '0;
        wait_ev("rand_idle", 2, 0, 40);

`ifdef FP_ARB_TIMEOUT_EN
        u_hang    = 1'b1;
        u_lat_fix = 3;
        set_req(0, 8'd1, $urandom(), $urandom());
        wait_ev("tmo_done", 0, 0, 40);
        chk("tmo_err", req_err, 1);
        chk("tmo_result", req_result, 0);
        chk("tmo_reset_req_cycle", rstreq_cyc, start_cyc + TO);
        req[0] = 1'b0;
        u_hang = 1'b0;
        wait_ev("tmo_idle", 2, 0, 5);
        chk("tmo_idle_busy", busy, 0);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle floating-point custom-instruction unit among NREQ requesters.
- Typical requesters: int-to-float sample conversion, window multiply, magnitude stage.
- Each requester presents an opcode and two operands. The block issues the job with a one-cycle start pulse, gates the unit's clock enable while the job is in flight, captures the result on done, and returns it to the winning requester.
- Sits between the audio pipeline stages and the single `floatingpoint` instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- fp_width, 32, operand/result width.
- op_width, 8, opcode width (unit `n` input).
- TIMEOUT, 64, watchdog cycle limit in WAIT. Used only with FP_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request, level, held until its req_done.
- req_op  in  NREQ*op_width  opcodes, requester i at slice [i*op_width +: op_width].
- req_dataa  in  NREQ*fp_width  operand A per requester, same slicing.
- req_datab  in  NREQ*fp_width  operand B per requester.
- grant  out  NREQ  one-hot, owner of the current job; 0 when idle.
- req_done  out  NREQ  one-cycle pulse to the owner when its result is valid.
- req_result  out  fp_width  result, valid in the req_done cycle, held until the next capture.
- req_err  out  1  high with req_done when the job was aborted.
- busy  out  1  high in every state except IDLE.
- fp_clk_en  out  1  unit clock enable.
- fp_start  out  1  unit start pulse.
- fp_n  out  op_width  opcode to the unit.
- fp_dataa  out  fp_width  operand A to the unit.
- fp_datab  out  fp_width  operand B to the unit.
- fp_reset_req  out  1  unit soft-reset request.
- fp_done  in  1  unit done.
- fp_result  in  fp_width  unit result.

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=NREQ-1. All outputs 0, including registered operands and result.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req!=0, select the first set bit searching upward from last_grant+1, modulo NREQ.
  - Register grant, fp_n, fp_dataa, fp_datab from the winner's slices, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: fp_start=1 and fp_clk_en=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - fp_clk_en=1 and fp_start=0.
  - When fp_done is sampled high, capture fp_result into req_result and go to RESP.
- RESP:
  - req_done[owner]=1 for one cycle; fp_clk_en=0.
  - last_grant=owner; grant is cleared on exit; go to IDLE.
- Operand stability: fp_n, fp_dataa and fp_datab stay constant from ISSUE through WAIT. Requester input changes after the grant are ignored.
- Latency: req sampled at edge k gives fp_start high in cycle k+1. If fp_done is high in cycle m, req_done is high in cycle m+1. Minimum gap between consecutive fp_start pulses: fp latency + 3 cycles.
- Requester drops req after grant: the job still completes and req_done still pulses, and the requester must ignore it. No cancel.
- fp_done outside WAIT: ignored.
- Single requester: it is re-granted back-to-back, with one IDLE cycle between jobs.
- Reset mid-job: returns to IDLE immediately with no req_done. fp_clk_en drops asynchronously.

Optional Feature:
- Macro: FP_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. If TIMEOUT cycles elapse with no fp_done, pulse fp_reset_req for one cycle, set req_result=0 and req_err=1, and go to RESP. The owner gets req_done with req_err.
  - The counter clears on entry to ISSUE.
- Undefined: no counter; WAIT waits indefinitely. req_err and fp_reset_req are tied 0.

Test Plan:
- Reset: rst=1 mid-WAIT → all outputs 0 the same cycle; after release, busy=0 and grant=0.
- Single job: req=0001, op=2, dataa=0x00000005; the model returns 0x40A00000 after 6 cycles.
  - fp_start pulses once, one cycle after req.
  - req_done[0]=1 exactly one cycle after fp_done.
  - req_result=0x40A00000 and req_err=0.
- Round-robin fairness: req=1111 held for 8 jobs → grant order 0,1,2,3,0,1,2,3; each req_done goes only to its owner.
- Operand isolation: change req_dataa[1] after grant[1] → fp_dataa is unchanged until RESP; the result matches the original operand.
- Dropped request: req[2] falls after grant → the job completes; req_done[2] pulses; the next grant goes to the next pending requester above 2.
- Timeout (FP_ARB_TIMEOUT_EN, TIMEOUT=16): the model never asserts fp_done → fp_reset_req pulses at cycle 16 of WAIT; req_done and req_err=1; req_result=0; then back in IDLE.
